// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-wide dmem with no byte enables (RMW for sub-word stores).
// Optional macro LSU_MISALIGN_SPLIT_EN: split misaligned accesses over two words instead of trapping.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              dmem_RW,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR    = 3'd2,
        S_RESP  = 3'd3
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        S_RD_HI = 3'd4,
        S_WR_HI = 3'd5
`endif
    } state_t;

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [63:0] m;
        case (size)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            default: m = 64'h0000_0000_FFFF_FFFF;
        endcase
        return m << {off, 3'b000};
    endfunction

    // The 64-bit window is {high word, low word}; only the addressed lanes are replaced.
    function automatic logic [63:0] merge_store(input logic [63:0] win, input logic [1:0] size,
                                                input logic [1:0] off, input logic [31:0] data);
        logic [63:0] m;
        logic [63:0] d;
        m = lane_mask(size, off);
        d = {32'h0000_0000, data} << {off, 3'b000};
        return (win & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] extract_load(input logic [63:0] win, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [31:0] raw;
        logic [31:0] v;
        raw = 32'(win >> {off, 3'b000});
        case (f3)
            3'b000:  v = {{24{raw[7]}}, raw[7:0]};
            3'b001:  v = {{16{raw[15]}}, raw[15:0]};
            3'b010:  v = raw;
            3'b100:  v = {24'h00_0000, raw[7:0]};
            3'b101:  v = {16'h0000, raw[15:0]};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    state_t            state_r, state_s;
    logic              we_r;
    logic [2:0]        f3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [XLEN-1:0]   wdata_r;

    logic              dmem_rw_s, resp_valid_s, resp_err_s;
    logic [ADDR_W-1:0] dmem_address_s;
    logic [XLEN-1:0]   dmem_wdata_s, resp_rdata_s;

    logic              accept_s, req_illegal_s, req_mis_s;
    logic [ADDR_W-1:0] req_base_s, base_s;
    logic [63:0]       win_s;
    logic [XLEN-1:0]   merged_lo_s, loaded_s;

    assign req_ready     = (state_r == S_IDLE) && !rst;
    assign accept_s      = req_valid && req_ready;
    assign req_illegal_s = ~is_legal(req_we, req_funct3);
    assign req_mis_s     = is_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign req_base_s    = {req_addr[ADDR_W-1:2], 2'b00};
    assign base_s        = {addr_r[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              split_r;
    logic [XLEN-1:0]   lo_r, lo_s, hi_r, hi_s, merged_hi_s;
    logic [63:0]       merged_s;
    logic [ADDR_W-1:0] base_hi_s;

    // Word A+4 wraps naturally at the top of the address space.
    assign base_hi_s   = base_s + {{(ADDR_W-3){1'b0}}, 3'b100};
    assign win_s       = (state_r == S_RD_HI) ? {dmem_rdata, lo_r} : {32'h0000_0000, dmem_rdata};
    assign merged_s    = merge_store(win_s, f3_r[1:0], addr_r[1:0], wdata_r);
    assign merged_lo_s = merged_s[31:0];
    assign merged_hi_s = merged_s[63:32];
`else
    assign win_s       = {32'h0000_0000, dmem_rdata};
    assign merged_lo_s = 32'(merge_store(win_s, f3_r[1:0], addr_r[1:0], wdata_r));
`endif
    assign loaded_s    = extract_load(win_s, f3_r, addr_r[1:0]);

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_s        = state_r;
        dmem_rw_s      = 1'b0;
        dmem_address_s = '0;
        dmem_wdata_s   = '0;
        resp_valid_s   = 1'b0;
        resp_rdata_s   = '0;
        resp_err_s     = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        lo_s           = lo_r;
        hi_s           = hi_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (req_illegal_s) begin
`else
                    if (req_illegal_s || req_mis_s) begin
`endif
                        state_s      = S_RESP;
                        resp_valid_s = 1'b1;
                        resp_err_s   = 1'b1;
                    end else if (req_we && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00)) begin
                        state_s        = S_WR;
                        dmem_rw_s      = 1'b1;
                        dmem_address_s = req_base_s;
                        dmem_wdata_s   = req_wdata;
                    end else begin
                        state_s        = S_RD;
                        dmem_address_s = req_base_s;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_r) begin
                    state_s        = S_RD_HI;
                    lo_s           = dmem_rdata;
                    dmem_address_s = base_hi_s;
                end else if (we_r) begin
`else
                if (we_r) begin
`endif
                    state_s        = S_WR;
                    dmem_rw_s      = 1'b1;
                    dmem_address_s = base_s;
                    dmem_wdata_s   = merged_lo_s;
                end else begin
                    state_s      = S_RESP;
                    resp_valid_s = 1'b1;
                    resp_rdata_s = loaded_s;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_RD_HI: begin
                if (we_r) begin
                    state_s        = S_WR;
                    dmem_rw_s      = 1'b1;
                    dmem_address_s = base_s;
                    dmem_wdata_s   = merged_lo_s;
                    hi_s           = merged_hi_s;
                end else begin
                    state_s      = S_RESP;
                    resp_valid_s = 1'b1;
                    resp_rdata_s = loaded_s;
                end
            end
            S_WR: begin
                if (split_r) begin
                    state_s        = S_WR_HI;
                    dmem_rw_s      = 1'b1;
                    dmem_address_s = base_hi_s;
                    dmem_wdata_s   = hi_r;
                end else begin
                    state_s      = S_RESP;
                    resp_valid_s = 1'b1;
                end
            end
            S_WR_HI: begin
                state_s      = S_RESP;
                resp_valid_s = 1'b1;
            end
`else
            S_WR: begin
                state_s      = S_RESP;
                resp_valid_s = 1'b1;
            end
`endif
            S_RESP: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs toward dmem and the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_RW      <= 1'b0;
            dmem_address <= '0;
            dmem_wdata   <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            dmem_RW      <= dmem_rw_s;
            dmem_address <= dmem_address_s;
            dmem_wdata   <= dmem_wdata_s;
            resp_valid   <= resp_valid_s;
            resp_rdata   <= resp_rdata_s;
            resp_err     <= resp_err_s;
        end
    end

    // Request fields held for the whole access, captured on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            addr_r  <= '0;
            wdata_r <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_r <= 1'b0;
`endif
        end else if (accept_s) begin
            we_r    <= req_we;
            f3_r    <= req_funct3;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_r <= req_mis_s;
`endif
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Low read word and high merged word carried between split phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_r <= '0;
            hi_r <= '0;
        end else begin
            lo_r <= lo_s;
            hi_r <= hi_s;
        end
    end
`endif

endmodule
